// File: rtl/hw3_sqta_pkg.sv
// Shared constants and types for the HW3 SQTA stimulus/response checker.
package hw3_sqta_pkg;

  localparam int unsigned VEC_W     = 3;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned ROM_DEPTH = 8;

  // {X1,X2,X3} per index; the leftmost entry is index 7.
  localparam logic [ROM_DEPTH-1:0][VEC_W-1:0] STIM_ROM = {
    3'b000, 3'b111, 3'b101, 3'b010, 3'b100, 3'b011, 3'b101, 3'b000
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } cmp_tag_t;

endpackage

// File: rtl/hw3_sqta_cmp_pipe.sv
// Delay line carrying {valid, idx} from vector issue to response compare.
module hw3_sqta_cmp_pipe
  import hw3_sqta_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic             Clk,
  input  logic             flush_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             empty_c
);

  cmp_tag_t stage_q [LATENCY];

  always_ff @(posedge Clk or negedge flush_n) begin
    if (!flush_n) begin
      for (int i = 0; i < int'(LATENCY); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{valid: in_valid, idx: in_idx};
      for (int i = 1; i < int'(LATENCY); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Pipe is drained once no stage holds a pending compare.
  always_comb begin
    empty_c = 1'b1;
    for (int i = 0; i < int'(LATENCY); i++) begin
      if (stage_q[i].valid) empty_c = 1'b0;
    end
  end

  assign out_valid = stage_q[LATENCY-1].valid;
  assign out_idx   = stage_q[LATENCY-1].idx;

endmodule

// File: rtl/hw3_sqta_stim_checker.sv
// Drives the fixed SQTA stimulus sequence and scores the machine's responses
// against a loadable expected-response memory.
module hw3_sqta_stim_checker
  import hw3_sqta_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             WrEn,
  input  logic [IDX_W-1:0] WrAddr,
  input  logic [VEC_W-1:0] WrData,
  input  logic             Z1,
  input  logic             Z2,
  input  logic             Z3,
  output logic             X1,
  output logic             X2,
  output logic             X3,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [3:0]       ErrCnt,
  output logic [IDX_W-1:0] FirstErrIdx
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] x_q, x_d;
  logic             iss_valid_q, iss_valid_d;
  logic [IDX_W-1:0] iss_idx_q, iss_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0] first_idx_q, first_idx_d;
  logic             err_flag_q, err_flag_d;
  logic             clr_run;

  logic [VEC_W-1:0] exp_mem [ROM_DEPTH];

  logic             cmp_valid;
  logic [IDX_W-1:0] cmp_idx;
  logic             pipe_empty_c;
  logic             mismatch_c;

  hw3_sqta_cmp_pipe #(.LATENCY(LATENCY)) u_cmp_pipe (
    .Clk       (Clk),
    .flush_n   (Rst_n),
    .in_valid  (iss_valid_q),
    .in_idx    (iss_idx_q),
    .out_valid (cmp_valid),
    .out_idx   (cmp_idx),
    .empty_c   (pipe_empty_c)
  );

  // Expected memory is deliberately not reset so it survives a mid-run reset.
  always_ff @(posedge Clk) begin
    if (WrEn && !busy_q) exp_mem[WrAddr] <= WrData;
  end

  assign mismatch_c = cmp_valid && ({Z1, Z2, Z3} != exp_mem[cmp_idx]);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = '0;
    iss_valid_d = 1'b0;
    iss_idx_d   = idx_q;
    pass_d      = pass_q;
    clr_run     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d     = (DEPTH == 1) ? ST_DRAIN : ST_RUN;
          x_d         = STIM_ROM[0];
          iss_valid_d = 1'b1;
          iss_idx_d   = '0;
          idx_d       = IDX_W'(1);
          pass_d      = 1'b0;
          clr_run     = 1'b1;
        end
      end
      ST_RUN: begin
        x_d         = STIM_ROM[idx_q];
        iss_valid_d = 1'b1;
        iss_idx_d   = idx_q;
        idx_d       = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DEPTH - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!iss_valid_q && pipe_empty_c) begin
          state_d = ST_FIN;
          pass_d  = (err_cnt_q == 4'd0);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_q == ST_DRAIN) && (state_d == ST_FIN);
  end

  // Error scoring: saturating count, first failing index latched once per run.
  always_comb begin
    err_cnt_d   = err_cnt_q;
    first_idx_d = first_idx_q;
    err_flag_d  = err_flag_q;
    if (clr_run) begin
      err_cnt_d   = '0;
      first_idx_d = '0;
      err_flag_d  = 1'b0;
    end else if (mismatch_c) begin
      if (err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 4'd1;
      if (!err_flag_q) begin
        err_flag_d  = 1'b1;
        first_idx_d = cmp_idx;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      iss_valid_q <= 1'b0;
      iss_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      iss_valid_q <= iss_valid_d;
      iss_idx_q   <= iss_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_idx_q <= first_idx_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign {X1, X2, X3} = x_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Pass         = pass_q;
  assign ErrCnt       = err_cnt_q;
  assign FirstErrIdx  = first_idx_q;

endmodule

// File: tb/tb_hw3_sqta_stim_checker.sv
// Directed bench: two checkers (LATENCY 1 and 3) share controls, each looped
// back through a delay stub standing in for the SQTA machine.
module tb_hw3_sqta_stim_checker;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic       Start = 1'b0;
  logic       WrEn = 1'b0;
  logic [2:0] WrAddr = '0;
  logic [2:0] WrData = '0;

  logic       a_X1, a_X2, a_X3, a_Busy, a_Done, a_Pass;
  logic [3:0] a_ErrCnt;
  logic [2:0] a_First;
  logic       b_X1, b_X2, b_X3, b_Busy, b_Done, b_Pass;
  logic [3:0] b_ErrCnt;
  logic [2:0] b_First;

  logic [2:0]      xa, xb, za, zb, za_q;
  logic [3:0][2:0] shb;
  logic [1:0]      b_sel = 2'd2;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int na, nb, c0;

  logic [7:0][2:0] rom_tb = {3'b000, 3'b111, 3'b101, 3'b010,
                             3'b100, 3'b011, 3'b101, 3'b000};

  always #5 Clk = ~Clk;

  assign xa = {a_X1, a_X2, a_X3};
  assign xb = {b_X1, b_X2, b_X3};
  assign za = za_q;
  assign zb = shb[b_sel];

  always @(posedge Clk) begin
    za_q <= xa;
    shb  <= {shb[2:0], xb};
  end

  always @(posedge Clk) if (a_Done === 1'b1) done_cnt++;

  hw3_sqta_stim_checker #(.DEPTH(8), .LATENCY(1)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .Z1(za[2]), .Z2(za[1]), .Z3(za[0]),
    .X1(a_X1), .X2(a_X2), .X3(a_X3), .Busy(a_Busy), .Done(a_Done),
    .Pass(a_Pass), .ErrCnt(a_ErrCnt), .FirstErrIdx(a_First)
  );

  hw3_sqta_stim_checker #(.DEPTH(8), .LATENCY(3)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .Z1(zb[2]), .Z2(zb[1]), .Z3(zb[0]),
    .X1(b_X1), .X2(b_X2), .X3(b_X3), .Busy(b_Busy), .Done(b_Done),
    .Pass(b_Pass), .ErrCnt(b_ErrCnt), .FirstErrIdx(b_First)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr1(input logic [2:0] addr, input logic [2:0] data);
    WrEn = 1'b1; WrAddr = addr; WrData = data;
    step();
    WrEn = 1'b0;
  endtask

  task automatic load_rom();
    for (int i = 0; i < 8; i++) wr1(3'(i), rom_tb[i]);
  endtask

  // Start a run; n counts edges after the Start edge T. Optional mid-run
  // write (addr 2, data 000) and Start pulse land on edges T+wr_at / T+st_at.
  task automatic run(input bit chk_x, input int wr_at, input int st_at,
                     output int da, output int db);
    int n;
    n = 0; da = 99; db = 99;
    Start = 1'b1;
    step();
    Start = 1'b0; WrEn = 1'b0;
    if (chk_x) begin
      chk("x_idx0", 32'(xa), 32'(rom_tb[0]));
      chk("busy_at_T", 32'(a_Busy), 32'd1);
    end
    while (n < 30 && (da == 99 || db == 99)) begin
      if (n + 1 == wr_at) begin WrEn = 1'b1; WrAddr = 3'd2; WrData = 3'b000; end
      if (n + 1 == st_at) Start = 1'b1;
      step();
      n++;
      WrEn = 1'b0; Start = 1'b0;
      if (chk_x && n <= 8) chk($sformatf("x_seq%0d", n), 32'(xa), n < 8 ? 32'(rom_tb[n]) : 32'd0);
      if (a_Done === 1'b1 && da == 99) da = n;
      if (b_Done === 1'b1 && db == 99) db = n;
    end
    repeat (3) step();
  endtask

  initial begin
    #2 Rst_n = 1'b0;
    repeat (5) step();
    chk("rst_x",     32'(xa),       32'd0);
    chk("rst_busy",  32'(a_Busy),   32'd0);
    chk("rst_done",  32'(a_Done),   32'd0);
    chk("rst_pass",  32'(a_Pass),   32'd0);
    chk("rst_err",   32'(a_ErrCnt), 32'd0);
    chk("rst_first", 32'(a_First),  32'd0);
    Rst_n = 1'b1;
    step();

    // Nominal loopback run, EXP = ROM.
    load_rom();
    run(1'b1, -1, -1, na, nb);
    chk("nom_done_t",  32'(na),       32'd10);
    chk("nom_pass",    32'(a_Pass),   32'd1);
    chk("nom_err",     32'(a_ErrCnt), 32'd0);
    chk("nom_first",   32'(a_First),  32'd0);
    chk("lat3_done_t", 32'(nb),       32'd12);
    chk("lat3_pass",   32'(b_Pass),   32'd1);

    // Two corrupted expectations.
    wr1(3'd3, 3'b111);
    wr1(3'd6, 3'b000);
    run(1'b0, -1, -1, na, nb);
    chk("bad_pass",  32'(a_Pass),   32'd0);
    chk("bad_err",   32'(a_ErrCnt), 32'd2);
    chk("bad_first", 32'(a_First),  32'd3);
    chk("bad3_err",  32'(b_ErrCnt), 32'd2);

    // Latency mismatch on the LATENCY=3 checker.
    load_rom();
    b_sel = 2'd1;
    run(1'b0, -1, -1, na, nb);
    chk("lmis_pass",    32'(b_Pass), 32'd0);
    chk("lmis_errnz",   32'(b_ErrCnt != 4'd0), 32'd1);
    chk("lmis_a_pass",  32'(a_Pass), 32'd1);
    b_sel = 2'd2;

    // Reset in the middle of a run.
    c0 = done_cnt;
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (4) step();
    Rst_n = 1'b0;
    #1;
    chk("mrst_x",    32'(xa),     32'd0);
    chk("mrst_busy", 32'(a_Busy), 32'd0);
    repeat (4) step();
    Rst_n = 1'b1;
    repeat (12) step();
    chk("mrst_nodone", 32'(done_cnt - c0), 32'd0);
    run(1'b0, -1, -1, na, nb);
    chk("mrst_pass", 32'(a_Pass), 32'd1);

    // Write while busy is ignored.
    run(1'b0, 3, -1, na, nb);
    chk("busywr_pass", 32'(a_Pass), 32'd1);

    // Same write in idle corrupts the next run.
    wr1(3'd2, 3'b000);
    run(1'b0, -1, -1, na, nb);
    chk("idlewr_pass",  32'(a_Pass),   32'd0);
    chk("idlewr_first", 32'(a_First),  32'd2);
    chk("idlewr_err",   32'(a_ErrCnt), 32'd1);

    // Write coincident with Start: the run sees the restored value.
    WrEn = 1'b1; WrAddr = 3'd2; WrData = 3'b011;
    run(1'b0, -1, -1, na, nb);
    chk("wrstart_pass", 32'(a_Pass), 32'd1);

    // Start pulsed while busy is ignored.
    c0 = done_cnt;
    run(1'b0, -1, 5, na, nb);
    chk("restart_done_t", 32'(na),            32'd10);
    chk("restart_ndone",  32'(done_cnt - c0), 32'd1);
    chk("restart_pass",   32'(a_Pass),        32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
